lane_gather: RTL and testbench

LANE_GATHER -- requirements
Module: lane_gather

---
 rtl/lake_lane_pkg.sv | 13 +
 rtl/lane_fifo.sv | 77 +++++++
 rtl/lane_gather.sv | 46 ++++
 tb/tb_lane_gather.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/lake_lane_pkg.sv
// rtl/lake_lane_pkg.sv - shared defaults and width helper for the lane gather block
package lake_lane_pkg;

    localparam int DEF_NUM_LANES  = 2;
    localparam int DEF_LANE_WIDTH = 1;
    localparam int DEF_DEPTH      = 2;

    // One extra bit so a full FIFO (count == DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - single-lane FIFO with registered accept flag, flush and occupancy count
module lane_fifo
    import lake_lane_pkg::*;
#(
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int CW        = count_width(DEPTH),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push_valid,
    input  logic [LANE_WIDTH-1:0] push_data,
    output logic                  push_ready,
    input  logic                  pop,
    output logic [LANE_WIDTH-1:0] head_data,
    output logic [CW-1:0]         count,
    output logic                  empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [LANE_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  ready_q;
    logic                  push_fire;
    logic [CW-1:0]         count_next;

    // ready_q is held low through reset and only reflects the count afterwards,
    // so a lane that is full this cycle refuses data even if it is popped.
    assign push_ready = ready_q;
    assign push_fire  = push_valid & ready_q;
    assign head_data  = mem[rd_ptr];
    assign empty      = (count == '0);

    always_comb begin
        count_next = count;
        if (push_fire && !pop) begin
            count_next = count + 1'b1;
        end else if (!push_fire && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            ready_q <= (count_next != DEPTH_C);
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/lane_gather.sv
// rtl/lane_gather.sv - joins per-lane FIFOs into one packed word popped in lockstep
module lane_gather
    import lake_lane_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int CW        = count_width(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_flush,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] i_lane_data,
    input  logic [NUM_LANES-1:0]            i_lane_valid,
    output logic [NUM_LANES-1:0]            o_lane_ready,
    output logic [NUM_LANES*LANE_WIDTH-1:0] o_data_out,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [NUM_LANES*CW-1:0]         o_occupancy
);

    logic [NUM_LANES-1:0] lane_empty;
    logic                 pop;

    assign o_valid = &(~lane_empty);
    assign pop     = o_valid & i_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_fifo #(
            .LANE_WIDTH (LANE_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (i_flush),
            .push_valid (i_lane_valid[k]),
            .push_data  (i_lane_data[k*LANE_WIDTH +: LANE_WIDTH]),
            .push_ready (o_lane_ready[k]),
            .pop        (pop),
            .head_data  (o_data_out[k*LANE_WIDTH +: LANE_WIDTH]),
            .count      (o_occupancy[k*CW +: CW]),
            .empty      (lane_empty[k])
        );
    end

endmodule

// File: tb/tb_lane_gather.sv
// tb/tb_lane_gather.sv - scoreboard bench for lane_gather with two 1-bit lanes of depth 2
module tb_lane_gather;

    localparam int NL    = 2;
    localparam int LW    = 1;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_flush = 1'b0;
    logic [NL*LW-1:0]  i_lane_data = '0;
    logic [NL-1:0]     i_lane_valid = '0;
    logic [NL-1:0]     o_lane_ready;
    logic [NL*LW-1:0]  o_data_out;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [NL*CW-1:0]  o_occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic mq0[$];
    logic mq1[$];
    bit   rdy_en = 1'b0;
    bit   chk_en = 1'b0;

    lane_gather #(
        .NUM_LANES  (NL),
        .LANE_WIDTH (LW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (i_flush),
        .i_lane_data  (i_lane_data),
        .i_lane_valid (i_lane_valid),
        .o_lane_ready (o_lane_ready),
        .o_data_out   (o_data_out),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_occupancy  (o_occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle: compare outputs against the model, advance the model, step the clock.
    task automatic cyc(input string tag, input logic [1:0] v, input logic [1:0] d,
                       input logic rdy, input logic fl, input logic rn);
        logic [1:0] e_rdy;
        logic       e_val;
        logic [3:0] e_occ;
        i_lane_valid = v;
        i_lane_data  = d;
        i_ready      = rdy;
        i_flush      = fl;
        rst_n        = rn;
        e_rdy[0] = rdy_en && (mq0.size() < DEPTH);
        e_rdy[1] = rdy_en && (mq1.size() < DEPTH);
        e_val    = (mq0.size() > 0) && (mq1.size() > 0);
        e_occ    = {2'(mq1.size()), 2'(mq0.size())};
        if (chk_en) begin
            check({tag, "/ready"}, 32'(o_lane_ready), 32'(e_rdy));
            check({tag, "/valid"}, 32'(o_valid), 32'(e_val));
            check({tag, "/occ"}, 32'(o_occupancy), 32'(e_occ));
            if (e_val) begin
                check({tag, "/data"}, 32'(o_data_out), 32'({mq1[0], mq0[0]}));
            end
        end
        if (!rn) begin
            mq0.delete();
            mq1.delete();
            rdy_en = 1'b0;
        end else if (fl) begin
            mq0.delete();
            mq1.delete();
            rdy_en = 1'b1;
        end else begin
            if (e_val && rdy) begin
                void'(mq0.pop_front());
                void'(mq1.pop_front());
            end
            if (v[0] && e_rdy[0]) mq0.push_back(d[0]);
            if (v[1] && e_rdy[1]) mq1.push_back(d[1]);
            rdy_en = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    initial begin
        repeat (3) cyc("rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        cyc("r036_c0", 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc("r036_wait", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("r036_c3", 2'b10, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("r036_c4", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("r036_c5", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

        cyc("r037_p1", 2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
        cyc("r037_p0", 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("r037_full", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("r037_out1", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("r037_out0", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("r037_end", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

        cyc("r038_f0", 2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
        cyc("r038_f1", 2'b11, 2'b10, 1'b0, 1'b0, 1'b1);
        cyc("r038_n0", 2'b11, 2'b01, 1'b1, 1'b0, 1'b1);
        cyc("r038_n1", 2'b11, 2'b10, 1'b1, 1'b0, 1'b1);
        cyc("r038_n2", 2'b11, 2'b11, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc("r038_drain", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

        cyc("r039_l0a", 2'b01, 2'b01, 1'b0, 1'b0, 1'b1);
        cyc("r039_l0b", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("r039_l1", 2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
        cyc("r039_flush", 2'b11, 2'b11, 1'b1, 1'b1, 1'b1);
        cyc("r039_after", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

        cyc("r040_f0", 2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
        cyc("r040_f1", 2'b11, 2'b01, 1'b0, 1'b0, 1'b1);
        cyc("r040_rst", 2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc("r040_rel", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("r040_new", 2'b11, 2'b10, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc("r040_out", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cyc("rand", 2'($urandom), 2'($urandom), 1'($urandom),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
        end
        repeat (4) cyc("final_drain", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
